pulse_period_meter: RTL and testbench

Measures the spacing, in clock cycles, between successive single-cycle event pulses such as the `zero` tick of a period downcounter. It is the receive side of that tick interface: a downcounter loaded with period P produces pulses that this block reports as P. Completed measurements are presented on a valid/ready output port for a display or compare stage, with saturation and loss flags.

---
 rtl/pulse_meter_pkg.sv | 10 +
 rtl/sat_upcounter.sv | 28 ++
 rtl/pulse_period_meter.sv | 103 ++++++++++
 tb/tb_pulse_period_meter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_meter_pkg.sv
// Shared types for the pulse period meter.
package pulse_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MEASURE
    } state_t;

endpackage

// File: rtl/sat_upcounter.sv
// Interval counter: clear beats load-to-one beats increment; holds at all-ones.
module sat_upcounter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load1,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    assign at_max = (count == '1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load1) begin
            count <= {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pulse_period_meter.sv
// Measures cycles between successive event pulses and presents each result
// on a valid/ready port with saturation and overwrite flags.
module pulse_period_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             pulse_in,
    input  logic             ready,
    output logic [WIDTH-1:0] period_out,
    output logic             overflow,
    output logic             valid,
    output logic             missed
);

    state_t           state;
    state_t           next_state;
    logic             clear;
    logic             load1;
    logic             inc;
    logic             capture;
    logic [WIDTH-1:0] count;
    logic             at_max;

    sat_upcounter #(.WIDTH(WIDTH)) u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .load1   (load1),
        .inc     (inc),
        .count   (count),
        .at_max  (at_max)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable) next_state = ARMED;
            ARMED: begin
                if (!enable)       next_state = IDLE;
                else if (pulse_in) next_state = MEASURE;
            end
            MEASURE: if (!enable) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Dropping enable clears the count and ignores any event in that cycle.
    always_comb begin
        clear   = 1'b0;
        load1   = 1'b0;
        inc     = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: clear = 1'b1;
            ARMED: begin
                if (!enable)       clear = 1'b1;
                else if (pulse_in) load1 = 1'b1;
            end
            MEASURE: begin
                if (!enable) begin
                    clear = 1'b1;
                end else if (pulse_in) begin
                    capture = 1'b1;
                    load1   = 1'b1;
                end else begin
                    inc = 1'b1;
                end
            end
            default: clear = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_out <= '0;
            overflow   <= 1'b0;
            valid      <= 1'b0;
            missed     <= 1'b0;
        end else begin
            missed <= capture && valid && !ready;
            if (capture) begin
                period_out <= count;
                overflow   <= at_max;
                valid      <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Drives a 16-bit and a 4-bit meter with shared stimulus and checks both
// against a timestamp-based reference model.
module tb_pulse_period_meter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        pulse_in;
    logic        ready;
    logic [15:0] period16;
    logic        ov16, valid16, missed16;
    logic [3:0]  period4;
    logic        ov4, valid4, missed4;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    longint cyc;
    bit     en_prev;
    bit     t_ok   [2];
    longint t_last [2];
    logic   m_valid[2];
    logic   m_ov   [2];
    logic   m_miss [2];
    longint m_per  [2];
    longint maxv   [2];

    always #5 clk = ~clk;

    pulse_period_meter #(.WIDTH(16)) dut16 (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .pulse_in   (pulse_in),
        .ready      (ready),
        .period_out (period16),
        .overflow   (ov16),
        .valid      (valid16),
        .missed     (missed16)
    );

    pulse_period_meter #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .pulse_in   (pulse_in),
        .ready      (ready),
        .period_out (period4),
        .overflow   (ov4),
        .valid      (valid4),
        .missed     (missed4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        en_prev = 1'b0;
        for (int d = 0; d < 2; d++) begin
            t_ok[d]    = 1'b0;
            t_last[d]  = 0;
            m_valid[d] = 1'b0;
            m_ov[d]    = 1'b0;
            m_miss[d]  = 1'b0;
            m_per[d]   = 0;
        end
    endtask

    // An event counts only when enable was high in this and the previous cycle.
    task automatic model_step();
        bit     counts;
        bit     cap;
        longint p;
        for (int d = 0; d < 2; d++) begin
            counts = enable && en_prev && pulse_in;
            cap    = 1'b0;
            p      = 0;
            if (counts) begin
                if (t_ok[d]) begin
                    cap = 1'b1;
                    p   = cyc - t_last[d];
                end
                t_last[d] = cyc;
                t_ok[d]   = 1'b1;
            end
            if (!enable) t_ok[d] = 1'b0;
            m_miss[d] = cap && m_valid[d] && !ready;
            if (cap) begin
                m_valid[d] = 1'b1;
                m_per[d]   = (p > maxv[d]) ? maxv[d] : p;
                m_ov[d]    = (p >= maxv[d]);
            end else if (m_valid[d] && ready) begin
                m_valid[d] = 1'b0;
            end
        end
        en_prev = enable;
    endtask

    task automatic compare_all();
        check("period16", 32'(period16), 32'(m_per[0]));
        check("ovf16",    32'(ov16),     32'(m_ov[0]));
        check("valid16",  32'(valid16),  32'(m_valid[0]));
        check("missed16", 32'(missed16), 32'(m_miss[0]));
        check("period4",  32'(period4),  32'(m_per[1]));
        check("ovf4",     32'(ov4),      32'(m_ov[1]));
        check("valid4",   32'(valid4),   32'(m_valid[1]));
        check("missed4",  32'(missed4),  32'(m_miss[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        compare_all();
    endtask

    task automatic pulses(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            pulse_in = 1'b1;
            tick();
            pulse_in = 1'b0;
            for (int j = 1; j < gap; j++) tick();
        end
    endtask

    initial begin
        maxv[0] = 65535;
        maxv[1] = 15;
        cyc = 0;
        model_reset();
        reset_n  = 1'b0;
        enable   = 1'b0;
        pulse_in = 1'b0;
        ready    = 1'b0;

        #12;
        compare_all();
        reset_n = 1'b1;

        // Periodic pulses every 5 with ready high
        enable = 1'b1;
        ready  = 1'b1;
        tick();
        pulses(4, 5);
        check("p5_value", 32'(period16), 32'd5);
        check("p5_ovf", 32'(ov16), 32'd0);

        // Back-to-back events
        pulse_in = 1'b1;
        tick();
        tick();
        pulse_in = 1'b0;
        check("p1_value", 32'(period16), 32'd1);
        tick();

        // Saturation on the narrow instance, then a short period
        pulses(2, 20);
        check("sat_value4", 32'(period4), 32'd15);
        check("sat_ovf4", 32'(ov4), 32'd1);
        check("nosat_value16", 32'(period16), 32'd20);
        pulses(2, 3);
        check("after_sat_value4", 32'(period4), 32'd3);
        check("after_sat_ovf4", 32'(ov4), 32'd0);

        // Backpressure: results overwrite and flag missed
        ready = 1'b0;
        pulses(3, 4);
        check("bp_valid", 32'(valid16), 32'd1);
        check("bp_value", 32'(period16), 32'd4);
        ready = 1'b1;
        tick();
        check("bp_accept_clears", 32'(valid16), 32'd0);
        ready = 1'b0;
        pulses(2, 4);
        ready    = 1'b1;
        pulse_in = 1'b1;
        tick();
        pulse_in = 1'b0;
        check("accept_on_capture_valid", 32'(valid16), 32'd1);
        check("accept_on_capture_missed", 32'(missed16), 32'd0);
        tick();

        // Enable drop mid-interval
        pulses(1, 2);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        enable = 1'b1;
        tick();
        pulses(2, 6);
        check("reenable_value", 32'(period16), 32'd6);

        // Asynchronous reset with a pending result
        ready = 1'b0;
        pulses(2, 3);
        check("pre_reset_valid", 32'(valid16), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        pulses(2, 7);

        // Randomised traffic
        for (int i = 0; i < 2500; i++) begin
            pulse_in = ($urandom_range(0, 5) == 0);
            ready    = $urandom_range(0, 1) == 1;
            enable   = ($urandom_range(0, 60) != 0);
            if ($urandom_range(0, 300) == 0) pulse_in = 1'b1;
            tick();
            if ($urandom_range(0, 200) == 0) begin
                pulse_in = 1'b0;
                enable   = 1'b1;
                for (int k = 0; k < 40; k++) tick();
                pulse_in = 1'b1;
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
